// File: rtl/idma_desc_submit_pkg.sv
// Shared types and constants for the iDMA descriptor submit arbiter.
// Holds the FSM encoding, the channel-ID width helper and the DESC_ADDR register offset.
package idma_desc_submit_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    localparam logic [63:0] DESC_ADDR_OFFSET = 64'h0;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idma_desc_submit_arb_if.sv
// Channel-side submit handshake plus the frontend reg-bus port of the submit arbiter.
// slave is the arbiter's view; master is the view of whatever drives the channels and the reg bus.
interface idma_desc_submit_arb_if #(
    parameter int unsigned NumChan   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
);
    logic [NumChan-1:0]           chan_valid_i;
    logic [NumChan*AddrWidth-1:0] chan_addr_i;
    logic [NumChan-1:0]           chan_ready_o;
    logic [NumChan-1:0]           chan_done_o;
    logic [NumChan-1:0]           chan_err_o;

    logic [AddrWidth-1:0]   reg_addr_o;
    logic                   reg_write_o;
    logic [DataWidth-1:0]   reg_wdata_o;
    logic [DataWidth/8-1:0] reg_wstrb_o;
    logic                   reg_valid_o;
    logic                   reg_ready_i;
    logic                   reg_error_i;

    modport slave (
        input  chan_valid_i, chan_addr_i, reg_ready_i, reg_error_i,
        output chan_ready_o, chan_done_o, chan_err_o,
               reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o, reg_valid_o
    );

    modport master (
        output chan_valid_i, chan_addr_i, reg_ready_i, reg_error_i,
        input  chan_ready_o, chan_done_o, chan_err_o,
               reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o, reg_valid_o
    );

endinterface

// File: rtl/idma_desc_submit_id_fifo.sv
// In-order FIFO of channel IDs for chains in flight; head is readable combinationally.
// Push into a full FIFO is accepted only together with a pop; pop on empty is ignored.
module idma_desc_submit_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           push_dat,
    input  logic                       pop,
    output logic [Width-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CntW'(Depth));
    assign empty    = (count == '0);
    assign pop_ok   = pop & ~empty;
    // The pop frees the slot this push lands in, so full only blocks a lone push.
    assign push_ok  = push & (~full | pop_ok);
    assign head_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= (wptr == PtrW'(Depth - 1)) ? '0 : wptr + PtrW'(1);
            end
            if (pop_ok) begin
                rptr <= (rptr == PtrW'(Depth - 1)) ? '0 : rptr + PtrW'(1);
            end
            count <= count + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

endmodule

// File: rtl/idma_desc_submit_arb.sv
// Round-robin arbiter feeding chain heads from NumChan requesters into the desc64 DESC_ADDR register.
// Grant one cycle after valid, held on the reg bus until reg_ready_i; stops granting while MaxOutstanding chains are in flight.
module idma_desc_submit_arb
    import idma_desc_submit_pkg::*;
#(
    parameter int unsigned          NumChan        = 4,
    parameter int unsigned          AddrWidth      = 64,
    parameter int unsigned          DataWidth      = 64,
    parameter int unsigned          MaxOutstanding = 4,
    parameter logic [AddrWidth-1:0] DescAddrOffset = AddrWidth'(DESC_ADDR_OFFSET)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    idma_desc_submit_arb_if.slave               bus,
    input  logic                                dma_done_i,
    output logic                                busy_o,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                spurious_done_o
);
    localparam int unsigned IdW  = id_width(NumChan);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    state_e               state_q;
    state_e               state_d;
    logic [IdW-1:0]       rr_q;
    logic [IdW-1:0]       grant_q;
    logic [AddrWidth-1:0] addr_q;

    logic                 pick_vld;
    logic [IdW-1:0]       pick_idx;
    logic [AddrWidth-1:0] pick_addr;
    logic [IdW:0]         scan_sum;
    logic [IdW-1:0]       scan_idx;

    logic                 fire;
    logic                 grant_ok;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [IdW-1:0]       fifo_head;
    logic [CntW-1:0]      fifo_count;

    // First requesting channel at or after the round-robin pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NumChan; k++) begin
            scan_sum = {1'b0, rr_q} + (IdW + 1)'(k);
            if (scan_sum >= (IdW + 1)'(NumChan)) begin
                scan_sum = scan_sum - (IdW + 1)'(NumChan);
            end
            scan_idx = scan_sum[IdW-1:0];
            if (!pick_vld && bus.chan_valid_i[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        for (int k = 0; k < NumChan; k++) begin
            if (pick_idx == IdW'(k)) begin
                pick_addr = bus.chan_addr_i[k*AddrWidth +: AddrWidth];
            end
        end
    end

    assign fifo_pop  = dma_done_i & ~fifo_empty;
    assign fire      = (state_q == WRITE) & bus.reg_ready_i;
    assign fifo_push = fire & ~bus.reg_error_i;
    // A completion in the same cycle frees a slot, so a full tracker may still grant.
    assign grant_ok  = pick_vld & (~fifo_full | fifo_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (grant_ok) state_d = WRITE;
            WRITE: if (bus.reg_ready_i) state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.reg_valid_o  = 1'b0;
        bus.reg_write_o  = 1'b0;
        bus.reg_addr_o   = '0;
        bus.reg_wdata_o  = '0;
        bus.reg_wstrb_o  = '0;
        bus.chan_ready_o = '0;
        bus.chan_err_o   = '0;
        bus.chan_done_o  = '0;
        if (state_q == WRITE) begin
            bus.reg_valid_o = 1'b1;
            bus.reg_write_o = 1'b1;
            bus.reg_addr_o  = DescAddrOffset;
            bus.reg_wdata_o = DataWidth'(addr_q);
            bus.reg_wstrb_o = '1;
            if (bus.reg_ready_i) begin
                bus.chan_ready_o[grant_q] = 1'b1;
                bus.chan_err_o[grant_q]   = bus.reg_error_i;
            end
        end
        if (fifo_pop) begin
            bus.chan_done_o[fifo_head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q    <= '0;
            grant_q <= '0;
            addr_q  <= '0;
        end else begin
            if ((state_q == IDLE) && grant_ok) begin
                grant_q <= pick_idx;
                addr_q  <= pick_addr;
            end
            if (fire) begin
                rr_q <= (grant_q == IdW'(NumChan - 1)) ? '0 : grant_q + IdW'(1);
            end
        end
    end

    idma_desc_submit_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (fifo_push),
        .push_dat (grant_q),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign busy_o          = (state_q != IDLE) | ~fifo_empty;
    assign outstanding_o   = fifo_count;
    assign spurious_done_o = dma_done_i & fifo_empty;

endmodule

// File: tb/tb_idma_desc_submit_arb.sv
// Bench for idma_desc_submit_arb: vector table, directed corner sequences and a random run
// checked every cycle against a submission-queue reference model.
module tb_idma_desc_submit_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       dma_done;
    logic       busy;
    logic [2:0] outst;
    logic       spur;
    logic [63:0] ch_addr [4];

    idma_desc_submit_arb_if #(.NumChan(4), .AddrWidth(64), .DataWidth(64)) bus ();

    assign bus.chan_addr_i = {ch_addr[3], ch_addr[2], ch_addr[1], ch_addr[0]};

    idma_desc_submit_arb #(
        .NumChan        (4),
        .AddrWidth      (64),
        .DataWidth      (64),
        .MaxOutstanding (4),
        .DescAddrOffset (64'h0)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus             (bus),
        .dma_done_i      (dma_done),
        .busy_o          (busy),
        .outstanding_o   (outst),
        .spurious_done_o (spur)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the write in flight (if any), the rr position and the queue of chains in flight.
    bit          chk_en = 1'b0;
    bit          m_wr = 1'b0;
    int          m_grant = 0;
    int          m_rr = 0;
    logic [63:0] m_addr = '0;
    int          q[$];
    logic [3:0]  acc_mask = '0;
    bit          m_fire, m_pop, m_full, m_found;
    logic [3:0]  e_rdy, e_done, e_err;
    logic [154:0] m_act, m_exp;

    always @(negedge clk) begin
        m_fire = m_wr && bus.reg_ready_i;
        m_pop  = dma_done && (q.size() > 0);
        m_full = (q.size() >= 4);
        e_rdy  = m_fire ? (4'(1) << m_grant) : 4'h0;
        e_err  = (m_fire && bus.reg_error_i) ? (4'(1) << m_grant) : 4'h0;
        e_done = 4'h0;
        if (m_pop) e_done = 4'(1) << q[0];
        m_act = {bus.reg_valid_o, bus.reg_write_o, bus.reg_addr_o, bus.reg_wdata_o, bus.reg_wstrb_o,
                 bus.chan_ready_o, bus.chan_done_o, bus.chan_err_o, busy, outst, spur};
        m_exp = {m_wr, m_wr, 64'h0, (m_wr ? m_addr : 64'h0), (m_wr ? 8'hFF : 8'h00),
                 e_rdy, e_done, e_err, (m_wr || q.size() != 0), 3'(q.size()),
                 (dma_done && q.size() == 0)};
        if (chk_en) check("model", m_act, m_exp);
        acc_mask = bus.chan_ready_o;
        if (rst) begin
            m_wr = 1'b0;
            m_rr = 0;
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_fire && !bus.reg_error_i) q.push_back(m_grant);
            if (m_wr) begin
                if (m_fire) begin
                    m_wr = 1'b0;
                    m_rr = (m_grant + 1) % 4;
                end
            end else if (bus.chan_valid_i != 0 && (!m_full || m_pop)) begin
                m_found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!m_found && bus.chan_valid_i[(m_rr + k) % 4]) begin
                        m_found = 1'b1;
                        m_grant = (m_rr + k) % 4;
                    end
                end
                m_addr = ch_addr[m_grant];
                m_wr   = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [3:0]  valid;
        logic        rdy;
        logic        err;
        logic        done;
        logic [3:0]  e_rdy;
        logic [3:0]  e_done;
        logic [3:0]  e_err;
        logic        e_rv;
        logic [63:0] e_wd;
        logic [2:0]  e_out;
        logic        e_spur;
    } vec_t;

    vec_t vt [11];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.chan_valid_i = '0;
        bus.reg_ready_i  = 1'b0;
        bus.reg_error_i  = 1'b0;
        dma_done         = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int order [6];
    int when  [6];
    int n_acc;
    int guard;
    int drain_exp [3];

    initial begin
        ch_addr[0] = 64'h1000_0000_0000_0A00;
        ch_addr[1] = 64'hF000_0000_0000_0000;
        ch_addr[2] = 64'h2222_3333_4444_5500;
        ch_addr[3] = 64'h0000_00AB_CDEF_0100;
        rst = 1'b1;
        bus.chan_valid_i = '0;
        bus.reg_ready_i  = 1'b0;
        bus.reg_error_i  = 1'b0;
        dma_done         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("reset_state", {bus.reg_valid_o, bus.reg_write_o, bus.reg_wdata_o, bus.reg_wstrb_o,
                              bus.chan_ready_o, bus.chan_done_o, bus.chan_err_o, busy, outst, spur}, '0);
        cyc();

        // Single submission from ch1, then an errored write from ch2 while ch1 is still in flight.
        vt[0]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 3'd0, 1'b0};
        vt[1]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, ch_addr[1], 3'd0, 1'b0};
        vt[2]  = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 4'h0, 4'h0, 1'b1, ch_addr[1], 3'd0, 1'b0};
        vt[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 3'd1, 1'b0};
        vt[4]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 3'd1, 1'b0};
        vt[5]  = '{4'b0101, 1'b1, 1'b1, 1'b0, 4'b0100, 4'h0, 4'b0100, 1'b1, ch_addr[2], 3'd1, 1'b0};
        vt[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 3'd1, 1'b0};
        vt[7]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0010, 4'h0, 1'b0, 64'h0, 3'd1, 1'b0};
        vt[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 3'd0, 1'b0};
        vt[9]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 3'd0, 1'b1};
        vt[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 3'd0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.chan_valid_i = vt[i].valid;
            bus.reg_ready_i  = vt[i].rdy;
            bus.reg_error_i  = vt[i].err;
            dma_done         = vt[i].done;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {bus.chan_ready_o, bus.chan_done_o, bus.chan_err_o, bus.reg_valid_o,
                   bus.reg_wdata_o, bus.reg_wstrb_o, outst, spur},
                  {vt[i].e_rdy, vt[i].e_done, vt[i].e_err, vt[i].e_rv,
                   vt[i].e_wd, (vt[i].e_rv ? 8'hFF : 8'h00), vt[i].e_out, vt[i].e_spur});
            cyc();
        end

        // Fairness: all channels requesting, reg bus always ready, a completion every cycle.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            order[k] = 99;
            when[k]  = 99;
        end
        n_acc = 0;
        bus.chan_valid_i = 4'b1111;
        bus.reg_ready_i  = 1'b1;
        dma_done         = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (bus.chan_ready_o != 0) begin
                if (n_acc < 6) begin
                    order[n_acc] = $clog2(bus.chan_ready_o);
                    when[n_acc]  = t;
                end
                n_acc++;
            end
            cyc();
        end
        check("fair_count", n_acc, 6);
        check("fair_first_cycle", when[0], 1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("fair_order%0d", k), order[k], k % 4);
            if (k > 0) check($sformatf("fair_gap%0d", k), when[k] - when[k-1], 2);
        end

        // Full: four chains accepted, the fifth request waits until a completion frees a slot.
        do_reset();
        bus.chan_valid_i = 4'b1111;
        bus.reg_ready_i  = 1'b1;
        n_acc = 0;
        guard = 0;
        while (n_acc < 4 && guard < 40) begin
            @(negedge clk);
            if (bus.chan_ready_o != 0) n_acc++;
            guard++;
            cyc();
        end
        check("full_accepts", n_acc, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_hold", {bus.reg_valid_o, busy, outst}, {1'b0, 1'b1, 3'd4});
            cyc();
        end
        dma_done = 1'b1;
        @(negedge clk);
        check("full_pop_done", {bus.chan_done_o, bus.reg_valid_o}, {4'b0001, 1'b0});
        cyc();
        dma_done        = 1'b0;
        bus.reg_ready_i = 1'b0;
        @(negedge clk);
        check("full_fifth_granted", {bus.reg_valid_o, bus.reg_wdata_o, outst}, {1'b1, ch_addr[0], 3'd3});
        cyc();
        bus.reg_ready_i = 1'b1;
        dma_done        = 1'b1;
        @(negedge clk);
        check("push_pop_same", {bus.chan_ready_o, bus.chan_done_o, outst}, {4'b0001, 4'b0010, 3'd3});
        cyc();
        bus.chan_valid_i = '0;
        bus.reg_ready_i  = 1'b0;
        dma_done         = 1'b0;
        @(negedge clk);
        check("push_pop_count", outst, 3'd3);
        cyc();
        drain_exp = '{2, 3, 0};
        for (int k = 0; k < 3; k++) begin
            dma_done = 1'b1;
            @(negedge clk);
            check($sformatf("drain%0d", k), bus.chan_done_o, 4'(1) << drain_exp[k]);
            cyc();
        end
        dma_done = 1'b0;

        // Reset while a write is stalled with three chains in flight.
        do_reset();
        bus.chan_valid_i = 4'b1111;
        bus.reg_ready_i  = 1'b1;
        n_acc = 0;
        guard = 0;
        while (n_acc < 3 && guard < 40) begin
            @(negedge clk);
            if (bus.chan_ready_o != 0) n_acc++;
            guard++;
            cyc();
        end
        bus.reg_ready_i = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_pre", {bus.reg_valid_o, outst}, {1'b1, 3'd3});
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_after", {bus.reg_valid_o, outst, busy}, {1'b0, 3'd0, 1'b0});
        cyc();
        @(negedge clk);
        check("rst_mid_rr", {bus.reg_valid_o, bus.reg_wdata_o}, {1'b1, ch_addr[0]});
        cyc();
        bus.chan_valid_i = '0;
        bus.reg_ready_i  = 1'b1;
        cyc();
        bus.reg_ready_i = 1'b0;
        cyc();

        // Random traffic: channels hold valid until accepted, then drop it.
        do_reset();
        for (int cy = 0; cy < 3000; cy++) begin
            for (int c = 0; c < 4; c++) begin
                if (acc_mask[c]) begin
                    bus.chan_valid_i[c] = 1'b0;
                end else if (!bus.chan_valid_i[c] && $urandom_range(0, 3) == 0) begin
                    ch_addr[c] = {$urandom, $urandom};
                    bus.chan_valid_i[c] = 1'b1;
                end
            end
            bus.reg_ready_i = 1'($urandom_range(0, 1));
            bus.reg_error_i = ($urandom_range(0, 9) == 0);
            dma_done        = ($urandom_range(0, 2) == 0);
            rst             = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst              = 1'b0;
        bus.chan_valid_i = '0;
        bus.reg_ready_i  = 1'b0;
        bus.reg_error_i  = 1'b0;
        dma_done         = 1'b0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
